mmio_bridge: RTL and testbench

//  Address-decoding bridge between the multicycle datapath's data-memory port and MemorySingleCycle.

---
 rtl/mmio_pkg.sv | 24 ++
 rtl/btn_debounce.sv | 52 +++++
 rtl/mmio_bridge.sv | 103 ++++++++++
 tb/tb_mmio_bridge.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// +--------------------------------------------------------------------------+
// | mmio_pkg : shared decode constants and register-offset enum for the      |
// |            MMIO bridge.                        Revision: 1.0              |
// +--------------------------------------------------------------------------+
`default_nettype none

package mmio_pkg;

  localparam logic [3:0] IO_REGION_NIBBLE = 4'hF;

  typedef enum logic [1:0] {
    OFF_LED   = 2'd0,
    OFF_BTN   = 2'd1,
    OFF_EDGE  = 2'd2,
    OFF_CYCLE = 2'd3
  } io_off_e;

  function automatic logic is_io(input logic [31:0] addr);
    return addr[31:28] == IO_REGION_NIBBLE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// +--------------------------------------------------------------------------+
// | btn_debounce : single-bit 2-flop synchronizer plus hold-time debouncer.   |
// |                                                Revision: 1.0              |
// +--------------------------------------------------------------------------+
`default_nettype none

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 150000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic db_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronized level agrees with the output restarts the hold window.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync_q[1] != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  assign db_o = db_q;

endmodule

`default_nettype wire

// File: rtl/mmio_bridge.sv
// +--------------------------------------------------------------------------+
// | mmio_bridge : decodes addr[31:28]==F as LED/BTN/EDGE/CYCLE registers,    |
// |               passes every other access straight to data memory.         |
// |                                                Revision: 1.0              |
// +--------------------------------------------------------------------------+
`default_nettype none

module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 150000,
  parameter int NUM_BTN         = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        dp_addr,
  input  logic [31:0]        dp_store_data,
  input  logic [3:0]         dp_store_we,
  output logic [31:0]        dp_load_data,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_store_data,
  output logic [3:0]         mem_store_we,
  input  logic [31:0]        mem_load_data,
  input  logic [NUM_BTN-1:0] btn_i,
  input  logic               halt_i,
  output logic [7:0]         led_o
);

  logic               io_hit;
  io_off_e            off;
  logic [31:0]        io_rdata;
  logic [NUM_BTN-1:0] btn_db;
  logic [NUM_BTN-1:0] edge_clr;

  logic [7:0]         led_q, led_d;
  logic [NUM_BTN-1:0] edge_q, edge_d;
  logic [NUM_BTN-1:0] db_prev_q;
  logic [31:0]        cycle_q, cycle_d;

  assign io_hit = is_io(dp_addr);
  assign off    = io_off_e'(dp_addr[3:2]);

  assign mem_addr       = dp_addr;
  assign mem_store_data = dp_store_data;
  assign mem_store_we   = io_hit ? 4'b0000 : dp_store_we;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .raw_i(btn_i[i]),
      .db_o (btn_db[i])
    );
  end

  always_comb begin
    io_rdata = '0;
    unique case (off)
      OFF_LED:   io_rdata = 32'(led_q);
      OFF_BTN:   io_rdata = 32'(btn_db);
      OFF_EDGE:  io_rdata = 32'(edge_q);
      OFF_CYCLE: io_rdata = cycle_q;
      default:   io_rdata = '0;
    endcase
  end

  assign dp_load_data = io_hit ? io_rdata : mem_load_data;

  // A rise in the same cycle as a W1C clear must survive, so the set term is ORed last.
  always_comb begin
    led_d    = led_q;
    edge_clr = '0;
    if (io_hit && (off == OFF_LED) && dp_store_we[0]) begin
      led_d = dp_store_data[7:0];
    end
    if (io_hit && (off == OFF_EDGE) && dp_store_we[0]) begin
      edge_clr = dp_store_data[NUM_BTN-1:0];
    end
    edge_d  = (edge_q & ~edge_clr) | (btn_db & ~db_prev_q);
    cycle_d = cycle_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q     <= '0;
      edge_q    <= '0;
      db_prev_q <= '0;
      cycle_q   <= '0;
    end else begin
      led_q     <= led_d;
      edge_q    <= edge_d;
      db_prev_q <= btn_db;
      cycle_q   <= cycle_d;
    end
  end

  assign led_o = {led_q[7:1], halt_i | led_q[0]};

endmodule

`default_nettype wire

// File: tb/tb_mmio_bridge.sv
// +--------------------------------------------------------------------------+
// | tb_mmio_bridge : scoreboard bench for mmio_bridge with a short debounce. |
// |                                                Revision: 1.0              |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mmio_bridge;

  localparam int NB = 7;
  localparam logic [31:0] A_LED   = 32'hF000_0000;
  localparam logic [31:0] A_BTN   = 32'hF000_0004;
  localparam logic [31:0] A_EDGE  = 32'hF000_0008;
  localparam logic [31:0] A_CYCLE = 32'hF000_000C;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   dp_addr, dp_store_data, dp_load_data;
  logic [3:0]    dp_store_we;
  logic [31:0]   mem_addr, mem_store_data, mem_load_data;
  logic [3:0]    mem_store_we;
  logic [NB-1:0] btn_i;
  logic          halt_i;
  logic [7:0]    led_o;

  int n_vec = 0;
  int n_err = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mmio_bridge #(
    .DEBOUNCE_CYCLES(4),
    .NUM_BTN        (NB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dp_addr       (dp_addr),
    .dp_store_data (dp_store_data),
    .dp_store_we   (dp_store_we),
    .dp_load_data  (dp_load_data),
    .mem_addr      (mem_addr),
    .mem_store_data(mem_store_data),
    .mem_store_we  (mem_store_we),
    .mem_load_data (mem_load_data),
    .btn_i         (btn_i),
    .halt_i        (halt_i),
    .led_o         (led_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue an expected load value, sample at the falling edge, then advance one cycle.
  task automatic rd(input logic [31:0] addr, input string tag, input logic [31:0] exp);
    dp_addr     = addr;
    dp_store_we = 4'b0000;
    tag_q.push_back(tag);
    exp_q.push_back(exp);
    @(negedge clk);
    check(tag_q.pop_front(), dp_load_data, exp_q.pop_front());
    step();
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
    dp_addr       = addr;
    dp_store_data = data;
    dp_store_we   = we;
    step();
    dp_store_we   = 4'b0000;
  endtask

  initial begin
    rst = 1'b1; dp_addr = '0; dp_store_data = '0; dp_store_we = '0;
    mem_load_data = '0; btn_i = '0; halt_i = 1'b0;
    repeat (3) step();

    @(negedge clk);
    check("rst_led_o", 32'(led_o), 32'h0);
    step();
    rd(A_CYCLE, "rst_cycle", 32'h0);

    // CYCLE counts edges since reset release
    rst = 1'b0;
    repeat (5) step();
    rd(A_CYCLE, "cycle_n", 32'd5);

    // Pass-through
    dp_addr = 32'h0000_0010; dp_store_data = 32'h1234_5678; dp_store_we = 4'hF;
    @(negedge clk);
    check("pt_we", 32'(mem_store_we), 32'hF);
    check("pt_addr", mem_addr, 32'h0000_0010);
    check("pt_data", mem_store_data, 32'h1234_5678);
    step();
    mem_load_data = 32'hDEAD_BEEF;
    rd(32'h0000_0010, "pt_load", 32'hDEAD_BEEF);
    dp_addr = A_LED; dp_store_data = 32'h1234_5678; dp_store_we = 4'hF;
    @(negedge clk);
    check("io_we_block", 32'(mem_store_we), 32'h0);
    step();
    dp_store_we = 4'h0;
    @(negedge clk);
    check("led_full_we", 32'(led_o), 32'h78);
    step();

    // LED
    wr(A_LED, 32'h0000_00A5, 4'b0001);
    @(negedge clk);
    check("led_o_a5", 32'(led_o), 32'hA5);
    step();
    rd(A_LED, "led_rd", 32'h0000_00A5);
    rd(32'hF123_4560, "led_alias", 32'h0000_00A5);
    wr(A_LED, 32'h0000_005A, 4'b0010);
    rd(A_LED, "led_we1_ign", 32'h0000_00A5);
    wr(A_LED, 32'h0, 4'b0001);
    halt_i = 1'b1;
    @(negedge clk);
    check("led_halt", 32'(led_o), 32'h01);
    step();
    halt_i = 1'b0;
    wr(A_BTN, 32'hFF, 4'hF);
    rd(A_BTN, "btn_ro", 32'h0);

    // Debounce: BTN becomes 0x08 exactly 6 edges after the raw change
    btn_i[3] = 1'b1;
    for (int k = 0; k <= 6; k++)
      rd(A_BTN, $sformatf("db_k%0d", k), (k == 6) ? 32'h08 : 32'h0);
    rd(A_EDGE, "edge_set", 32'h08);

    // 3-cycle glitch on bit 0 is filtered
    btn_i[0] = 1'b1;
    repeat (3) step();
    btn_i[0] = 1'b0;
    for (int k = 0; k < 8; k++)
      rd(A_BTN, $sformatf("glitch_k%0d", k), 32'h08);

    // Edge W1C
    rd(A_EDGE, "edge_hold", 32'h08);
    wr(A_EDGE, 32'h08, 4'b0001);
    rd(A_EDGE, "edge_clr", 32'h0);
    btn_i[3] = 1'b0;
    repeat (7) step();
    rd(A_BTN, "btn_fall", 32'h0);
    rd(A_EDGE, "no_fall_flag", 32'h0);
    btn_i[3] = 1'b1;
    repeat (6) step();
    wr(A_EDGE, 32'h08, 4'b0001);
    rd(A_EDGE, "set_wins", 32'h08);

    // CYCLE wrap
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_q;
    step();
    rd(A_CYCLE, "cycle_wrap", 32'h0);
    rd(A_CYCLE, "cycle_after", 32'h1);

    // Reset mid-operation
    wr(A_LED, 32'hFF, 4'b0001);
    btn_i = 7'b000_0010;
    repeat (3) step();
    rst = 1'b1; halt_i = 1'b1;
    step();
    @(negedge clk);
    check("rst2_led_o", 32'(led_o), 32'h01);
    step();
    rd(A_LED, "rst2_led", 32'h0);
    rd(A_BTN, "rst2_btn", 32'h0);
    rd(A_EDGE, "rst2_edge", 32'h0);
    rd(A_CYCLE, "rst2_cycle", 32'h0);
    halt_i = 1'b0;
    @(negedge clk);
    check("rst2_led_nohalt", 32'(led_o), 32'h0);
    step();
    rst = 1'b0;
    for (int k = 0; k <= 6; k++)
      rd(A_BTN, $sformatf("redb_k%0d", k), (k == 6) ? 32'h02 : 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
